tail_light_seq: RTL and testbench
=================================

Name: tail_light_seq

Overview:
- Parametrised successor to the fixed 3+3-lamp tail-light controller.
- Drives N_LAMPS lamps per side with sequential turn signals, brake, hazard (alarm) and fog modes. Modes are resolved by a fixed priority.
- A prescaler sets the step rate, so the block runs from the system clock instead of a dedicated 1 Hz clock.
- Sits between the driver-input debouncers and the lamp output drivers.

Parameters:
- N_LAMPS, 3, lamps per side; must be >= 2. Bit 0 is the innermost lamp (a), bit N_LAMPS-1 the outermost.
- DIV, 1, clock cycles per sequence step; must be >= 1. DIV=1 gives one step per clock.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- left  in  1  left turn request, level
- right  in  1  right turn request, level
- brake  in  1  brake pedal, level
- alarm  in  1  hazard request, level
- fog  in  1  fog lamp request, level
- l_lamps  out  N_LAMPS  left lamp drive, registered
- r_lamps  out  N_LAMPS  right lamp drive, registered
- step_tick  out  1  one-cycle pulse on the last cycle of each step, for debug/sync

Behaviour:
- One clock; reset is synchronous and active-high. While reset=1 at a rising edge: state=IDLE, prescaler=0, step index=0, l_lamps=0, r_lamps=0, step_tick=0. Reset overrides every input and takes effect mid-sequence the same way.
- Prescaler counts 0..DIV-1. step_tick=1 when prescaler==DIV-1.
  - Prescaler clears to 0 on every state change, so the first step of any new mode lasts exactly DIV cycles.
- States: IDLE, LEFT_SEQ, RIGHT_SEQ, HAZARD, BRAKE, FOG.
- Priority, evaluated every edge: alarm > (left & right) > brake > left/right > fog > IDLE.
  - left & right together are treated as HAZARD.
- Latency: outputs update on the same rising edge that samples the input change. No extra pipeline stage.
- IDLE: both outputs 0.
- LEFT_SEQ: l_lamps steps through thermometer codes 1, 3, 7, ..., 2^N_LAMPS-1, then 0, each held DIV cycles; r_lamps=0.
  - Entry pattern is 1 (innermost lamp on).
  - After the all-off step: if left is still 1, restart at 1; otherwise go to IDLE.
  - Releasing left mid-sequence does not cut the sequence: it runs through all-lit and all-off, then exits.
- RIGHT_SEQ: mirror of LEFT_SEQ on r_lamps.
- Opposite request during a running sequence: the current sequence completes its all-off step, then the other side starts. Both held at once means HAZARD.
- HAZARD: both sides all-ones for DIV cycles, then all-zeros for DIV cycles, repeating; starts on.
  - On release, move immediately (same edge) to the next-priority mode.
- BRAKE: both sides all-ones, steady. Preempts a turn sequence immediately; the step index resets to 0.
- FOG: bit 0 on both sides steady, other bits 0.
- Preemption by a higher-priority mode aborts the turn sequence. On return, LEFT_SEQ/RIGHT_SEQ restart at entry pattern 1.
- Step index width is clog2(N_LAMPS+1). Prescaler width is clog2(DIV), minimum 1 bit.

Optional Feature:
- Macro: TAIL_LIGHT_BRAKE_TURN_EN.
- Defined: brake together with exactly one turn request gives that side the turn sequence and the other side steady all-ones. The sequence restarts at 1 on brake assertion. alarm and left&right still win.
- Undefined: brake overrides turn requests completely; both sides are all-ones.

Test Plan (N_LAMPS=3, DIV=1 unless noted):
- Reset 3 cycles, then left=1 for 4 cycles -> l_lamps 001, 011, 111, 000; r_lamps=000 throughout. Left low before the next step -> IDLE, outputs 000.
- left=1 for 1 cycle only -> full sequence 001, 011, 111, 000 still plays, then IDLE.
- Run left, brake=1 at step 011 (macro undefined) -> next edge both 111. Release brake with left=1 -> l_lamps restarts at 001.
- alarm=1 for 6 cycles -> both sides 111, 000, 111, 000, 111, 000. alarm=0 -> 000 on the next edge.
- fog=1 for 3 cycles -> both 001. Then brake=1, fog=0 -> both 111. Reset asserted mid-LEFT_SEQ -> all 0 on the next edge.
- DIV=3, N_LAMPS=4, right=1 -> r_lamps 0001, 0011, 0111, 1111, 0000, each held 3 cycles; step_tick pulses every third cycle.
- TAIL_LIGHT_BRAKE_TURN_EN defined, brake=1 and right=1 -> l_lamps=111 steady, r_lamps sequences from 001.

Source files
------------

// File: rtl/tail_light_if.sv
// Request/lamp bundle between the driver-input debouncers and the tail-light
// sequencer.
//   master : drives left/right/brake/alarm/fog, observes l_lamps/r_lamps/step_tick
//   slave  : the sequencer (receives requests, drives lamps and step_tick)
// N_LAMPS must match the N_LAMPS of the attached tail_light_seq.
interface tail_light_if #(
    parameter int unsigned N_LAMPS = 3
);
    logic               left;
    logic               right;
    logic               brake;
    logic               alarm;
    logic               fog;
    logic [N_LAMPS-1:0] l_lamps;
    logic [N_LAMPS-1:0] r_lamps;
    logic               step_tick;

    modport master (
        output left, right, brake, alarm, fog,
        input  l_lamps, r_lamps, step_tick
    );

    modport slave (
        input  left, right, brake, alarm, fog,
        output l_lamps, r_lamps, step_tick
    );
endinterface

// File: rtl/tail_light_seq.sv
// Parametrised tail-light controller: sequential turn signals, brake, hazard
// and fog modes on N_LAMPS lamps per side, stepped by a clock prescaler.
// Mode priority: alarm > (left & right) > brake > left/right > fog > idle.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : tail_light_if.slave (requests in; l_lamps/r_lamps/step_tick out,
//            all registered)
// Parameters:
//   N_LAMPS : lamps per side (>= 2), bit 0 innermost
//   DIV     : clock cycles per sequence step (>= 1)
// Build option:
//   TAIL_LIGHT_BRAKE_TURN_EN : when defined, brake plus exactly one turn
//   request sequences that side while the other side shows steady brake.
module tail_light_seq #(
    parameter int unsigned N_LAMPS = 3,
    parameter int unsigned DIV     = 1
) (
    input  logic         clk,
    input  logic         reset,
    tail_light_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_LAMPS + 1);
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_OFF  = IDX_W'(N_LAMPS);
    localparam logic [N_LAMPS-1:0] ALL_ON   = {N_LAMPS{1'b1}};
    localparam logic [N_LAMPS-1:0] INNER_ON = N_LAMPS'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEFT_SEQ,
        RIGHT_SEQ,
        HAZARD,
        BRAKE,
        FOG
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_LAMPS-1:0] l_lamps_q, l_lamps_d;
    logic [N_LAMPS-1:0] r_lamps_q, r_lamps_d;
    logic               step_tick_q, step_tick_d;

    logic   step_end_c;
    logic   haz_req_c;
    logic   seq_run_c;
    logic   restart_c;
    state_e base_mode_c;

`ifdef TAIL_LIGHT_BRAKE_TURN_EN
    logic brake_q;
`endif

    // Thermometer pattern for a turn step; the step after all-lit is all-off.
    function automatic logic [N_LAMPS-1:0] seq_pattern(input logic [IDX_W-1:0] idx);
        logic [N_LAMPS-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_LAMPS; i++) begin
            if (idx != IDX_OFF && i <= 32'(idx)) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    assign step_end_c = (pre_q == PRE_LAST);
    assign haz_req_c  = bus.alarm | (bus.left & bus.right);
    assign seq_run_c  = (state_q == LEFT_SEQ) || (state_q == RIGHT_SEQ);

    // Mode chosen when no higher mode applies and no sequence is holding the lamps.
    always_comb begin
        base_mode_c = IDLE;
        if (bus.left) begin
            base_mode_c = LEFT_SEQ;
        end else if (bus.right) begin
            base_mode_c = RIGHT_SEQ;
        end else if (bus.fog) begin
            base_mode_c = FOG;
        end
    end

    // Next mode, step index and prescaler.
    always_comb begin
        state_d   = state_q;
        restart_c = 1'b0;
        pre_d     = pre_q;
        idx_d     = idx_q;

        if (haz_req_c) begin
            state_d = HAZARD;
`ifdef TAIL_LIGHT_BRAKE_TURN_EN
        end else if (bus.brake && (bus.left ^ bus.right)) begin
            state_d   = bus.left ? LEFT_SEQ : RIGHT_SEQ;
            restart_c = ~brake_q;
`endif
        end else if (bus.brake) begin
            state_d = BRAKE;
        end else if (seq_run_c && !(step_end_c && idx_q == IDX_OFF)) begin
            // A running turn sequence always plays through its all-off step.
            state_d = state_q;
        end else begin
            state_d = base_mode_c;
        end

        if (state_d != state_q || restart_c) begin
            pre_d = '0;
            idx_d = '0;
        end else if (step_end_c) begin
            pre_d = '0;
            case (state_q)
                LEFT_SEQ, RIGHT_SEQ: idx_d = (idx_q == IDX_OFF) ? '0 : idx_q + IDX_W'(1);
                HAZARD:              idx_d = idx_q ^ IDX_W'(1);
                default:             idx_d = '0;
            endcase
        end else begin
            pre_d = pre_q + PRE_W'(1);
            idx_d = idx_q;
        end
    end

    // Lamp patterns are derived from the next mode so they change on the
    // same edge that samples the request.
    always_comb begin
        l_lamps_d = '0;
        r_lamps_d = '0;
        case (state_d)
            LEFT_SEQ:  l_lamps_d = seq_pattern(idx_d);
            RIGHT_SEQ: r_lamps_d = seq_pattern(idx_d);
            HAZARD: begin
                if (!idx_d[0]) begin
                    l_lamps_d = ALL_ON;
                    r_lamps_d = ALL_ON;
                end
            end
            BRAKE: begin
                l_lamps_d = ALL_ON;
                r_lamps_d = ALL_ON;
            end
            FOG: begin
                l_lamps_d = INNER_ON;
                r_lamps_d = INNER_ON;
            end
            default: begin
                l_lamps_d = '0;
                r_lamps_d = '0;
            end
        endcase
`ifdef TAIL_LIGHT_BRAKE_TURN_EN
        // Brake with a turn sequence: the non-turning side shows steady brake.
        if (bus.brake && state_d == LEFT_SEQ) begin
            r_lamps_d = ALL_ON;
        end
        if (bus.brake && state_d == RIGHT_SEQ) begin
            l_lamps_d = ALL_ON;
        end
`endif
        step_tick_d = (pre_d == PRE_LAST);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            idx_q       <= '0;
            l_lamps_q   <= '0;
            r_lamps_q   <= '0;
            step_tick_q <= 1'b0;
`ifdef TAIL_LIGHT_BRAKE_TURN_EN
            brake_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            l_lamps_q   <= l_lamps_d;
            r_lamps_q   <= r_lamps_d;
            step_tick_q <= step_tick_d;
`ifdef TAIL_LIGHT_BRAKE_TURN_EN
            brake_q     <= bus.brake;
`endif
        end
    end

    assign bus.l_lamps   = l_lamps_q;
    assign bus.r_lamps   = r_lamps_q;
    assign bus.step_tick = step_tick_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: a 3-lamp/DIV=1 instance for the mode
// behaviour and a 4-lamp/DIV=3 instance for prescaled stepping.
module tb_tail_light_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    tail_light_if #(.N_LAMPS(3)) ifa ();
    tail_light_if #(.N_LAMPS(4)) ifb ();

    tail_light_seq #(.N_LAMPS(3), .DIV(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    tail_light_seq #(.N_LAMPS(4), .DIV(3)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] exp_l, input logic [2:0] exp_r);
        chk({tag, " l"}, 32'(ifa.l_lamps), 32'(exp_l));
        chk({tag, " r"}, 32'(ifa.r_lamps), 32'(exp_r));
    endtask

    task automatic set_a(input logic l, input logic r, input logic b, input logic a, input logic f);
        ifa.left  = l;
        ifa.right = r;
        ifa.brake = b;
        ifa.alarm = a;
        ifa.fog   = f;
    endtask

    initial begin
        logic [3:0] pat_b [5];
        logic [2:0] haz [6];
        pat_b = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0};
        haz   = '{3'h7, 3'h0, 3'h7, 3'h0, 3'h7, 3'h0};

        set_a(0, 0, 0, 0, 0);
        ifb.left = 0; ifb.right = 0; ifb.brake = 0; ifb.alarm = 0; ifb.fog = 0;

        // Reset for 3 cycles
        reset = 1'b1;
        tick(); tick(); tick();
        chk_a("reset", 3'b000, 3'b000);
        chk("reset tick_a", 32'(ifa.step_tick), 32'(0));
        chk("reset b l", 32'(ifb.l_lamps), 32'(0));
        chk("reset b r", 32'(ifb.r_lamps), 32'(0));
        chk("reset tick_b", 32'(ifb.step_tick), 32'(0));

        // Left held for 4 steps, then released -> idle
        reset = 1'b0;
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("left s0", 3'b001, 3'b000);
        chk("left tick_a", 32'(ifa.step_tick), 32'(1));
        tick(); chk_a("left s1", 3'b011, 3'b000);
        tick(); chk_a("left s2", 3'b111, 3'b000);
        tick(); chk_a("left s3", 3'b000, 3'b000);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("left idle", 3'b000, 3'b000);
        tick(); chk_a("left idle2", 3'b000, 3'b000);

        // One-cycle left pulse still plays the full sequence
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("pulse s0", 3'b001, 3'b000);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("pulse s1", 3'b011, 3'b000);
        tick(); chk_a("pulse s2", 3'b111, 3'b000);
        tick(); chk_a("pulse s3", 3'b000, 3'b000);
        tick(); chk_a("pulse idle", 3'b000, 3'b000);

        // Left held past all-off restarts at 001
        set_a(1, 0, 0, 0, 0);
        tick(); tick(); tick(); tick();
        chk_a("hold s3", 3'b000, 3'b000);
        tick(); chk_a("hold restart", 3'b001, 3'b000);
        set_a(0, 0, 0, 0, 0);
        tick(); tick(); tick(); tick();
        chk_a("hold drain idle", 3'b000, 3'b000);

`ifndef TAIL_LIGHT_BRAKE_TURN_EN
        // Brake preempts a running left sequence; release restarts at 001
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("brk s0", 3'b001, 3'b000);
        tick(); chk_a("brk s1", 3'b011, 3'b000);
        set_a(1, 0, 1, 0, 0);
        tick(); chk_a("brk on", 3'b111, 3'b111);
        tick(); chk_a("brk on2", 3'b111, 3'b111);
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("brk rel s0", 3'b001, 3'b000);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("brk rel s1", 3'b011, 3'b000);
        tick(); chk_a("brk rel s2", 3'b111, 3'b000);
        tick(); chk_a("brk rel s3", 3'b000, 3'b000);
        tick(); chk_a("brk idle", 3'b000, 3'b000);
`else
        // Brake with right: left steady on, right sequences from 001
        set_a(0, 1, 1, 0, 0);
        tick(); chk_a("bt s0", 3'b111, 3'b001);
        tick(); chk_a("bt s1", 3'b111, 3'b011);
        tick(); chk_a("bt s2", 3'b111, 3'b111);
        tick(); chk_a("bt s3", 3'b111, 3'b000);
        tick(); chk_a("bt s0b", 3'b111, 3'b001);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("bt rel s1", 3'b000, 3'b011);
        tick(); tick(); tick();
        chk_a("bt idle", 3'b000, 3'b000);
`endif

        // Alarm blinks both sides, release -> idle on the next edge
        set_a(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_a($sformatf("alarm c%0d", i), haz[i], haz[i]);
        end
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("alarm rel", 3'b000, 3'b000);

        // Left & right together is hazard
        set_a(1, 1, 0, 0, 0);
        tick(); chk_a("lr haz on", 3'b111, 3'b111);
        tick(); chk_a("lr haz off", 3'b000, 3'b000);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("lr haz rel", 3'b000, 3'b000);

        // Fog, then brake over fog
        set_a(0, 0, 0, 0, 1);
        tick(); chk_a("fog c0", 3'b001, 3'b001);
        tick(); chk_a("fog c1", 3'b001, 3'b001);
        tick(); chk_a("fog c2", 3'b001, 3'b001);
        set_a(0, 0, 1, 0, 0);
        tick(); chk_a("fog brake", 3'b111, 3'b111);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("brake rel", 3'b000, 3'b000);

        // Opposite request waits for the all-off step
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("opp l0", 3'b001, 3'b000);
        set_a(0, 1, 0, 0, 0);
        tick(); chk_a("opp l1", 3'b011, 3'b000);
        tick(); chk_a("opp l2", 3'b111, 3'b000);
        tick(); chk_a("opp l3", 3'b000, 3'b000);
        tick(); chk_a("opp r0", 3'b000, 3'b001);
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("opp r1", 3'b000, 3'b011);
        tick(); chk_a("opp r2", 3'b000, 3'b111);
        tick(); chk_a("opp r3", 3'b000, 3'b000);
        tick(); chk_a("opp idle", 3'b000, 3'b000);

        // Reset mid-sequence
        set_a(1, 0, 0, 0, 0);
        tick(); chk_a("rst s0", 3'b001, 3'b000);
        tick(); chk_a("rst s1", 3'b011, 3'b000);
        reset = 1'b1;
        tick(); chk_a("rst mid", 3'b000, 3'b000);
        chk("rst mid tick", 32'(ifa.step_tick), 32'(0));
        reset = 1'b0;
        set_a(0, 0, 0, 0, 0);
        tick(); chk_a("rst after", 3'b000, 3'b000);

        // N_LAMPS=4, DIV=3: each right step held 3 cycles, tick on the third
        ifb.right = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("b r s%0d c%0d", s, c), 32'(ifb.r_lamps), 32'(pat_b[s]));
                chk($sformatf("b l s%0d c%0d", s, c), 32'(ifb.l_lamps), 32'(0));
                chk($sformatf("b tick s%0d c%0d", s, c), 32'(ifb.step_tick), (c == 2) ? 32'(1) : 32'(0));
            end
        end
        tick();
        chk("b restart", 32'(ifb.r_lamps), 32'(4'h1));
        ifb.right = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
